down_timer: RTL

- Loadable down-counting timer with prescaler, one-shot/periodic modes, pause/resume and a single-cycle expiry pulse.
- It is the decrementing counterpart of the team's free-running up counter.
- Used for timeouts, watchdog windows and periodic event generation in the same clock domain as the up counter.

---
 rtl/timer_pkg.sv | 18 +
 rtl/down_timer_if.sv | 27 ++
 rtl/timer_prescaler.sv | 38 +++
 rtl/down_timer.sv | 116 +++++++++++
 4 files changed

// File: rtl/timer_pkg.sv
// Shared types and default widths for the down-counting timer.
package timer_pkg;

  localparam int unsigned DefDw = 8;
  localparam int unsigned DefPw = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2
  } state_e;

  typedef enum logic {
    ONE_SHOT = 1'b0,
    PERIODIC = 1'b1
  } mode_e;

endpackage

// File: rtl/down_timer_if.sv
// Control/status bundle for down_timer. master drives requests, slave is the timer.
interface down_timer_if #(
  parameter int unsigned DW = 8,
  parameter int unsigned PW = 4
);

  logic          load_i;
  logic [DW-1:0] load_val_i;
  logic [PW-1:0] psc_i;
  logic          mode_i;
  logic          start_i;
  logic          stop_i;
  logic [DW-1:0] count_o;
  logic          busy_o;
  logic          expire_o;

  modport master (
    output load_i, load_val_i, psc_i, mode_i, start_i, stop_i,
    input  count_o, busy_o, expire_o
  );

  modport slave (
    input  load_i, load_val_i, psc_i, mode_i, start_i, stop_i,
    output count_o, busy_o, expire_o
  );

endinterface

// File: rtl/timer_prescaler.sv
// Divide-by-(div+1) tick generator; the counter freezes whenever en_i is low.
module timer_prescaler #(
  parameter int unsigned PW = 4
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          clr_i,
  input  logic          en_i,
  input  logic [PW-1:0] div_i,
  output logic          tick_o
);

  logic [PW-1:0] cnt_q, cnt_d;
  logic          wrap;

  assign wrap   = (cnt_q == div_i);
  assign tick_o = en_i && wrap;

  // Next count: clear wins, otherwise step or wrap only while enabled.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = wrap ? '0 : cnt_q + PW'(1);
    end
  end

  // Prescaler counter register with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/down_timer.sv
// Loadable down-counting timer: prescaled decrement, one-shot/periodic, pause/resume,
// single-cycle expiry pulse on terminal count.
module down_timer
  import timer_pkg::*;
#(
  parameter int unsigned DW = DefDw,
  parameter int unsigned PW = DefPw
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  down_timer_if.slave bus
);

  state_e        state_q, state_d;
  mode_e         mode_q, mode_d;
  logic [DW-1:0] count_q, count_d;
  logic [DW-1:0] reload_q, reload_d;
  logic [PW-1:0] psc_q, psc_d;
  logic          expire_q, expire_d;
  logic          busy_q;
  logic          psc_en, psc_clr, tick;

  // Counter only advances on cycles where RUN actually continues (no load, no stop).
  assign psc_en  = (state_q == RUN) && !bus.load_i && !bus.stop_i;
  // Fresh start from IDLE restarts the prescale period; resume from PAUSE keeps it.
  assign psc_clr = bus.load_i || (bus.start_i && !bus.stop_i && (state_q == IDLE));

  timer_prescaler #(
    .PW (PW)
  ) u_prescaler (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .clr_i  (psc_clr),
    .en_i   (psc_en),
    .div_i  (psc_q),
    .tick_o (tick)
  );

  // Next-state: load > stop > start > decrement.
  always_comb begin
    state_d  = state_q;
    mode_d   = mode_q;
    count_d  = count_q;
    reload_d = reload_q;
    psc_d    = psc_q;
    expire_d = 1'b0;

    if (bus.load_i) begin
      count_d  = bus.load_val_i;
      reload_d = bus.load_val_i;
      psc_d    = bus.psc_i;
      mode_d   = mode_e'(bus.mode_i);
      state_d  = IDLE;
    end else if (bus.stop_i) begin
      if (state_q == RUN) begin
        state_d = PAUSE;
      end
    end else begin
      unique case (state_q)
        IDLE: begin
          // A zero count cannot be started, so RUN never sees count 0.
          if (bus.start_i && (count_q != '0)) begin
            state_d = RUN;
          end
        end
        PAUSE: begin
          if (bus.start_i) begin
            state_d = RUN;
          end
        end
        RUN: begin
          if (tick) begin
            if (count_q == DW'(1)) begin
              expire_d = 1'b1;
              if (mode_q == PERIODIC) begin
                count_d = reload_q;
              end else begin
                count_d = '0;
                state_d = IDLE;
              end
            end else begin
              count_d = count_q - DW'(1);
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // State and datapath registers; busy is registered alongside the state.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q  <= IDLE;
      mode_q   <= ONE_SHOT;
      count_q  <= '0;
      reload_q <= '0;
      psc_q    <= '0;
      expire_q <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      mode_q   <= mode_d;
      count_q  <= count_d;
      reload_q <= reload_d;
      psc_q    <= psc_d;
      expire_q <= expire_d;
      busy_q   <= (state_d == RUN);
    end
  end

  assign bus.count_o  = count_q;
  assign bus.busy_o   = busy_q;
  assign bus.expire_o = expire_q;

endmodule
